// File: rtl/sram_write_ctrl_if.sv
// Write-port bundle between the push-button/switch front end and the display RAM.
// The master drives the operator inputs; the slave (controller) drives the RAM write side.
interface sram_write_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              key_n;
  logic [DATA_W-1:0] sw_data;
  logic [ADDR_W-1:0] sw_addr;
  logic              addr_mode;
  logic              we;
  logic [DATA_W-1:0] d;
  logic [ADDR_W-1:0] write_add;
  logic [ADDR_W:0]   wr_count;
  logic              full;

  modport master (
    output key_n, sw_data, sw_addr, addr_mode,
    input  we, d, write_add, wr_count, full
  );

  modport slave (
    input  key_n, sw_data, sw_addr, addr_mode,
    output we, d, write_add, wr_count, full
  );
endinterface

// File: rtl/sram_write_ctrl.sv
// Debounced push-button write front end for the display RAM: one single-cycle write
// per accepted press, auto-increment or switch addressing, saturating write count.
//
//   state    | meaning
//   IDLE     | released and stable, waiting for a press
//   DEB_PRS  | press seen, counting stable pressed cycles
//   WRITE    | single cycle in which we is high
//   WAIT_REL | write done (or just out of reset), waiting for release
//   DEB_REL  | release seen, counting stable released cycles
module sram_write_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  sram_write_ctrl_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LAST_FREE = FULL_CNT - 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEB_PRS,
    S_WRITE,
    S_WAIT_REL,
    S_DEB_REL
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_key_s1;
  logic              r_key_s2;
  logic              r_we;
  logic [DATA_W-1:0] r_d;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_wr_count;
  logic              r_full;

  logic              w_pressed;
  logic [ADDR_W-1:0] w_wr_addr;

  assign w_pressed = ~r_key_s2;
  assign w_wr_addr = bus.addr_mode ? bus.sw_addr : r_ptr;

  // Starting in WAIT_REL means a key held through reset must be released before it can write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_WAIT_REL;
      r_cnt      <= '0;
      r_key_s1   <= 1'b1;
      r_key_s2   <= 1'b1;
      r_we       <= 1'b0;
      r_d        <= '0;
      r_addr     <= '0;
      r_ptr      <= '0;
      r_wr_count <= '0;
      r_full     <= 1'b0;
    end else begin
      r_key_s1 <= bus.key_n;
      r_key_s2 <= r_key_s1;
      r_we     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pressed) begin
            r_state <= S_DEB_PRS;
            r_cnt   <= '0;
          end
        end
        S_DEB_PRS: begin
          if (!w_pressed) begin
            r_state <= S_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_WRITE;
            r_we    <= 1'b1;
            r_d     <= bus.sw_data;
            r_addr  <= w_wr_addr;
            r_ptr   <= w_wr_addr + ADDR_W'(1);
            if (r_wr_count != FULL_CNT) begin
              r_wr_count <= r_wr_count + 1'b1;
            end
            r_full <= r_full | (r_wr_count == LAST_FREE);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WRITE: begin
          r_state <= S_WAIT_REL;
        end
        S_WAIT_REL: begin
          if (!w_pressed) begin
            r_state <= S_DEB_REL;
            r_cnt   <= '0;
          end
        end
        S_DEB_REL: begin
          if (w_pressed) begin
            r_state <= S_WAIT_REL;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_WAIT_REL;
        end
      endcase
    end
  end

  assign bus.we        = r_we;
  assign bus.d         = r_d;
  assign bus.write_add = r_addr;
  assign bus.wr_count  = r_wr_count;
  assign bus.full      = r_full;

endmodule
